bus_xfer_ctrl: RTL and testbench

Parametrised bus-transfer sequencer that moves one word from a selected source module to a selected destination module over the shared data bus. It is the single owner of bus drive: it asserts exactly one source output-enable and one destination write-enable per transfer and registers the bus word, so sources can never drive the bus simultaneously. Sources that need time to produce data, such as the EEPROM with its DONE flag, are waited on through a per-source ready line with a bounded timeout.

---
 rtl/bus_xfer_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: moves one word from a selected source to a selected
// destination over the shared data bus. This block alone drives the bus
// enables, so at most one source can drive the bus at any time.
//
// Ports
//   CLK       system clock, rising edge
//   RESET_N   synchronous active-low reset
//   req       start a transfer (sampled only while idle)
//   abort     cancel the in-flight transfer
//   src_sel   source index, latched at accept
//   dst_sel   destination index, latched at accept
//   src_data  flattened source words, source i at [i*WIDTH +: WIDTH]
//   src_rdy   per-source data-valid
//   src_oe    one-hot source output-enable
//   dst_we    one-hot destination write-enable (single cycle)
//   bus_out   registered bus word, held between transfers
//   busy      high while a transfer is in flight
//   done      one-cycle completion pulse
//   err       one-cycle failure pulse
//   err_code  01 bad select, 10 timeout; held until next accept or error
module bus_xfer_ctrl #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NSRC    = 8,
   parameter int unsigned NDST    = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic                    req,
   input  logic                    abort,
   input  logic [$clog2(NSRC)-1:0] src_sel,
   input  logic [$clog2(NDST)-1:0] dst_sel,
   input  logic [NSRC*WIDTH-1:0]   src_data,
   input  logic [NSRC-1:0]         src_rdy,
   output logic [NSRC-1:0]         src_oe,
   output logic [NDST-1:0]         dst_we,
   output logic [WIDTH-1:0]        bus_out,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [1:0]              err_code
);

   localparam int unsigned SW = $clog2(NSRC);
   localparam int unsigned DW = $clog2(NDST);
   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_SEL  = 2'b01;
   localparam logic [1:0] CODE_TMO  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SRC  = 2'd1,
      ST_DST  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t            state, state_d;
   logic [SW-1:0]     src_q, src_q_d;
   logic [DW-1:0]     dst_q, dst_q_d;
   logic [TW-1:0]     timer, timer_d;
   logic [WIDTH-1:0]  bus_d;
   logic [1:0]        code_d;
   logic              err_d;
   logic [NSRC-1:0]   src_oe_d;
   logic [NDST-1:0]   dst_we_d;
   logic              busy_d;
   logic              done_d;
   logic              sel_bad_c;
   logic              tmo_hit_c;

   // Unpack the flattened source words for indexed selection
   logic [WIDTH-1:0]  src_word [NSRC];

   for (genvar i = 0; i < NSRC; i++) begin : g_unpack
      assign src_word[i] = src_data[i*WIDTH +: WIDTH];
   end

   assign sel_bad_c = (32'(src_sel) >= NSRC) || (32'(dst_sel) >= NDST);
   // Current SRC cycle is the TIMEOUT-th one without ready
   assign tmo_hit_c = (TIMEOUT != 0) && ((32'(timer) + 32'd1) == TIMEOUT);

   // State register
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next state, datapath updates and next registered outputs
   always_comb begin
      state_d  = state;
      src_q_d  = src_q;
      dst_q_d  = dst_q;
      timer_d  = timer;
      bus_d    = bus_out;
      code_d   = err_code;
      err_d    = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (req) begin
               if (sel_bad_c) begin
                  err_d  = 1'b1;
                  code_d = CODE_SEL;
               end else begin
                  src_q_d = src_sel;
                  dst_q_d = dst_sel;
                  timer_d = '0;
                  code_d  = CODE_NONE;
                  state_d = ST_SRC;
               end
            end
         end
         ST_SRC: begin
            // abort > ready > timeout
            if (abort) begin
               state_d = ST_IDLE;
            end else if (src_rdy[src_q]) begin
               bus_d   = src_word[src_q];
               state_d = ST_DST;
            end else if (tmo_hit_c) begin
               err_d   = 1'b1;
               code_d  = CODE_TMO;
               state_d = ST_IDLE;
            end else begin
               timer_d = timer + TW'(1);
            end
         end
         ST_DST: begin
            state_d = abort ? ST_IDLE : ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register with it
      src_oe_d = (state_d == ST_SRC) ? (NSRC'(1) << src_q_d) : '0;
      dst_we_d = (state_d == ST_DST) ? (NDST'(1) << dst_q_d) : '0;
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_FIN);
   end

   // Datapath and output registers
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         src_q    <= '0;
         dst_q    <= '0;
         timer    <= '0;
         bus_out  <= '0;
         err_code <= CODE_NONE;
         err      <= 1'b0;
         src_oe   <= '0;
         dst_we   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         src_q    <= src_q_d;
         dst_q    <= dst_q_d;
         timer    <= timer_d;
         bus_out  <= bus_d;
         err_code <= code_d;
         err      <= err_d;
         src_oe   <= src_oe_d;
         dst_we   <= dst_we_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Testbench for bus_xfer_ctrl: directed cases plus randomized transfers
// checked against a transaction-level timeline model.
module tb_bus_xfer_ctrl;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned NSRC    = 6;
   localparam int unsigned NDST    = 7;
   localparam int unsigned TIMEOUT = 5;

   logic                    CLK;
   logic                    RESET_N;
   logic                    req;
   logic                    abort;
   logic [2:0]              src_sel;
   logic [2:0]              dst_sel;
   logic [NSRC*WIDTH-1:0]   src_data;
   logic [NSRC-1:0]         src_rdy;
   logic [NSRC-1:0]         src_oe;
   logic [NDST-1:0]         dst_we;
   logic [WIDTH-1:0]        bus_out;
   logic                    busy;
   logic                    done;
   logic                    err;
   logic [1:0]              err_code;

   int unsigned n_tot = 0;
   int unsigned n_bad = 0;
   logic        chk_en = 1'b0;
   logic [7:0]  exp_bus;
   logic [1:0]  exp_code;

   bus_xfer_ctrl #(
      .WIDTH   (WIDTH),
      .NSRC    (NSRC),
      .NDST    (NDST),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .req      (req),
      .abort    (abort),
      .src_sel  (src_sel),
      .dst_sel  (dst_sel),
      .src_data (src_data),
      .src_rdy  (src_rdy),
      .src_oe   (src_oe),
      .dst_we   (dst_we),
      .bus_out  (bus_out),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_code (err_code)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Enable exclusivity holds at every cycle
   always @(negedge CLK) begin
      if (chk_en) begin
         check("oe_onehot0", 32'($onehot0(src_oe)), 32'd1);
         check("we_onehot0", 32'($onehot0(dst_we)), 32'd1);
         check("oe_we_excl", 32'((|src_oe) && (|dst_we)), 32'd0);
      end
   end

   task automatic check_quiet(input string tag);
      check({tag, "_oe"},   32'(src_oe),   32'd0);
      check({tag, "_we"},   32'(dst_we),   32'd0);
      check({tag, "_bus"},  32'(bus_out),  32'd0);
      check({tag, "_busy"}, 32'(busy),     32'd0);
      check({tag, "_done"}, 32'(done),     32'd0);
      check({tag, "_err"},  32'(err),      32'd0);
      check({tag, "_code"}, 32'(err_code), 32'd0);
   endtask

   // One request: s/d selects, w = SRC cycles before ready, ab = abort cycle
   // (0 = none), hold keeps req high while busy. Called at #1 after an edge
   // with the DUT idle; that cycle is cycle 0 and req is sampled at its end.
   task automatic run_xfer(input int s, input int d, input int w, input int ab,
                           input bit hold, input logic [7:0] word);
      bit                    bad, tmo, live;
      int                    n_src, last_busy, abort_at, last_req;
      logic [NSRC*WIDTH-1:0] data;
      logic [NSRC-1:0]       rdy, e_oe, s_bit;
      logic [NDST-1:0]       e_we;
      logic                  e_busy, e_done, e_err;

      bad       = (s >= int'(NSRC)) || (d >= int'(NDST));
      tmo       = !bad && (w >= int'(TIMEOUT));
      n_src     = bad ? 0 : (tmo ? int'(TIMEOUT) : w + 1);
      last_busy = bad ? 0 : (tmo ? n_src : n_src + 2);
      abort_at  = (ab <= last_busy) ? ab : 0;
      last_req  = (abort_at != 0) ? abort_at : last_busy;
      s_bit     = NSRC'(1) << s;

      data = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--)
         data = (data << 8) | (NSRC*WIDTH)'((i == s) ? word : 8'($urandom));
      src_data = data;
      src_sel  = 3'(s);
      dst_sel  = 3'(d);
      req      = 1'b1;
      abort    = 1'b0;
      src_rdy  = NSRC'($urandom) & ~s_bit;

      for (int c = 1; c <= last_busy + 2; c++) begin
         @(posedge CLK);
         #1;
         live   = (abort_at == 0) || (c <= abort_at);
         e_oe   = '0;
         e_we   = '0;
         e_busy = 1'b0;
         e_done = 1'b0;
         e_err  = 1'b0;
         if (c == 1) exp_code = bad ? 2'b01 : 2'b00;
         if (bad && c == 1) e_err = 1'b1;
         if (live && !bad) begin
            if (c <= n_src) begin
               e_oe   = s_bit;
               e_busy = 1'b1;
            end else if (!tmo && c == n_src + 1) begin
               e_we    = NDST'(1) << d;
               e_busy  = 1'b1;
               exp_bus = word;
            end else if (!tmo && c == n_src + 2) begin
               e_done = 1'b1;
               e_busy = 1'b1;
            end else if (tmo && c == n_src + 1) begin
               e_err    = 1'b1;
               exp_code = 2'b10;
            end
         end
         check("src_oe",   32'(src_oe),   32'(e_oe));
         check("dst_we",   32'(dst_we),   32'(e_we));
         check("busy",     32'(busy),     32'(e_busy));
         check("done",     32'(done),     32'(e_done));
         check("err",      32'(err),      32'(e_err));
         check("err_code", 32'(err_code), 32'(exp_code));
         check("bus_out",  32'(bus_out),  32'(exp_bus));

         req     = hold && (c <= last_req);
         abort   = (c == abort_at);
         rdy     = NSRC'($urandom) & ~s_bit;
         src_rdy = rdy | ((c > w) ? s_bit : '0);
      end
      req   = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      int s, d, w, ab;
      bit hold;

      RESET_N  = 1'b0;
      req      = 1'b0;
      abort    = 1'b0;
      src_sel  = '0;
      dst_sel  = '0;
      src_data = '0;
      src_rdy  = '0;
      exp_bus  = 8'h00;
      exp_code = 2'b00;
      repeat (3) @(posedge CLK);
      #1;
      check_quiet("reset");
      RESET_N = 1'b1;
      chk_en  = 1'b1;

      run_xfer(3, 2, 0, 0, 1'b0, 8'hA5);   // zero-wait
      run_xfer(5, 1, 4, 0, 1'b0, 8'h3C);   // ready on final timeout cycle
      run_xfer(4, 0, 9, 0, 1'b0, 8'h77);   // timeout, bus_out kept
      run_xfer(7, 2, 0, 0, 1'b0, 8'h11);   // bad source
      run_xfer(1, 7, 0, 0, 1'b0, 8'h22);   // bad destination
      run_xfer(2, 3, 3, 2, 1'b0, 8'h5A);   // abort in SRC
      run_xfer(2, 3, 0, 2, 1'b0, 8'hC3);   // abort in DST, write stands
      run_xfer(0, 6, 0, 3, 1'b0, 8'h96);   // abort in FIN
      run_xfer(1, 4, 2, 0, 1'b1, 8'h69);   // req held while busy
      run_xfer(4, 5, 9, 0, 1'b0, 8'hE1);   // timeout sets err_code 10

      // Reset in the middle of SRC
      src_sel = 3'd4;
      dst_sel = 3'd0;
      src_rdy = '0;
      req     = 1'b1;
      @(posedge CLK);
      #1;
      check("rst_pre_oe", 32'(src_oe), 32'h10);
      req     = 1'b0;
      RESET_N = 1'b0;
      @(posedge CLK);
      #1;
      RESET_N  = 1'b1;
      exp_bus  = 8'h00;
      exp_code = 2'b00;
      check_quiet("rst_mid");
      @(posedge CLK);
      #1;
      check("rst_post_busy", 32'(busy), 32'd0);

      for (int k = 0; k < 80; k++) begin
         s    = int'($urandom_range(0, 7));
         d    = int'($urandom_range(0, 7));
         w    = int'($urandom_range(0, 7));
         ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
         hold = 1'($urandom_range(0, 1));
         run_xfer(s, d, w, ab, hold, 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
